// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode pipeline: opcodes, NOP encoding, fetch FSM states.
package cpu_pkg;

    localparam int OPC_W = 4;
    localparam logic [OPC_W-1:0] OPC_NOP = 4'b1111;
    localparam logic [15:0] NOP_INSTR = 16'hF000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } if_state_t;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'd0,
        OP_ADDI = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9,
        OP_NOP  = 4'd15
    } opcode_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds its contents.
// Latency: one cycle from load/bubble to outputs.
// Backpressure: the caller simply withholds load; the register keeps its value.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int INSTR_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc
);

    localparam logic [INSTR_W-1:0] NOP_W = {OPC_NOP, {(INSTR_W-OPC_W){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_W;
            id_pc    <= RESET_PC;
        end else if (bubble) begin
            // the pc is kept so downstream still sees where the bubble sits
            id_valid <= 1'b0;
            id_instr <= NOP_W;
        end else if (load) begin
            id_valid <= 1'b1;
            id_instr <= load_instr;
            id_pc    <= load_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the pc, reads imem over req/ack, fills the IF/ID register.
// Latency: ack in cycle N is visible on id_* in N+1; zero-wait memory gives one instr/cycle.
// Backpressure: id_stall parks one in-flight word in a skid buffer and drops imem_req until release.
module if_stage
    import cpu_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int INSTR_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [OPC_W-1:0]   id_opcode,
    output logic [PC_W-1:0]    id_pc
);

    localparam logic [INSTR_W-1:0] NOP_W = {OPC_NOP, {(INSTR_W-OPC_W){1'b0}}};

    if_state_t          state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    redir_tgt;
    logic               skid_vld;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    logic               ifid_load;
    logic               ifid_bubble;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc;

    assign imem_req  = (state == FETCH) || (state == DROP);
    assign imem_addr = pc;
    assign id_opcode = id_instr[INSTR_W-1 -: OPC_W];

    always_comb begin
        ifid_bubble = redirect_valid;
        ifid_load   = 1'b0;
        ifid_instr  = imem_rdata;
        ifid_pc     = pc;
        if (!redirect_valid) begin
            case (state)
                FETCH: ifid_load = imem_ack && !id_stall;
                HOLD: begin
                    ifid_load  = !id_stall && skid_vld;
                    ifid_instr = skid_instr;
                    ifid_pc    = skid_pc;
                end
                default: ifid_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_tgt  <= RESET_PC;
            skid_vld   <= 1'b0;
            skid_instr <= NOP_W;
            skid_pc    <= RESET_PC;
        end else begin
            if (redirect_valid)
                skid_vld <= 1'b0;
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect_valid)
                        pc <= redirect_pc;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            pc <= redirect_pc;
                        end else begin
                            // request cannot be retracted: ride it out in DROP
                            redir_tgt <= redirect_pc;
                            state     <= DROP;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + PC_W'(1);
                        if (id_stall) begin
                            skid_vld   <= 1'b1;
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!id_stall) begin
                        skid_vld <= 1'b0;
                        state    <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        pc    <= redirect_valid ? redirect_pc : redir_tgt;
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        redir_tgt <= redirect_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .load_instr (ifid_instr),
        .load_pc    (ifid_pc),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, zero-wait and slow memory, stall/skid, redirects, pc wrap, async reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [3:0]  id_opcode;
    logic [7:0]  id_pc;

    int tests  = 0;
    int failed = 0;

    // memory responder settings, evaluated once per cycle inside tick()
    bit auto_mem = 1'b1;
    int lat      = 0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_pc          (id_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (imem_req) begin
                if (wait_cnt == lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = {8'h00, imem_addr};
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    endtask

    // returns in the first cycle after rst deasserts
    task automatic do_reset();
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 16'h0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h0;
        wait_cnt       = 0;
        auto_mem       = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 16'h0;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h0;
        #1;
        check("rst_req",      imem_req,  1'b0);
        check("rst_addr",     imem_addr, 8'h00);
        check("rst_valid",    id_valid,  1'b0);
        check("rst_instr",    id_instr,  16'hF000);
        check("rst_opcode",   id_opcode, 4'hF);
        check("rst_pc",       id_pc,     8'h00);

        // zero-wait memory: first req in cycle 2, then one instruction per cycle
        lat = 0;
        do_reset();
        check("zw_c1_req", imem_req, 1'b0);
        tick();
        check("zw_c2_req",   imem_req,  1'b1);
        check("zw_c2_addr",  imem_addr, 8'h00);
        check("zw_c2_valid", id_valid,  1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zw_valid",  id_valid,  1'b1);
            check("zw_pc",     id_pc,     i);
            check("zw_opcode", id_opcode, 4'h0);
            check("zw_instr",  id_instr,  i);
            check("zw_req",    imem_req,  1'b1);
            check("zw_addr",   imem_addr, i + 1);
        end

        // slow memory: ack in the fourth req cycle
        lat = 3;
        do_reset();
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("slow_addr_hold", imem_addr, 8'h00);
            check("slow_req",       imem_req,  1'b1);
            check("slow_valid_lo",  id_valid,  1'b0);
        end
        check("slow_ack_c5", imem_ack, 1'b1);
        tick();
        check("slow_valid_hi", id_valid,  1'b1);
        check("slow_pc0",      id_pc,     8'h00);
        check("slow_next_req", imem_req,  1'b1);
        check("slow_next_adr", imem_addr, 8'h01);

        // stall for 4 cycles while addr 5 acks
        lat = 0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check("st_c7_addr", imem_addr, 8'h05);
        check("st_c7_pc",   id_pc,     8'h04);
        id_stall = 1'b1;
        tick();
        check("st_hold_req",   imem_req, 1'b0);
        check("st_hold_pc",    id_pc,    8'h04);
        check("st_hold_valid", id_valid, 1'b1);
        tick();
        tick();
        check("st_c10_pc", id_pc, 8'h04);
        tick();
        id_stall = 1'b0;
        check("st_c11_req", imem_req, 1'b0);
        tick();
        check("st_rel_pc",   id_pc,     8'h05);
        check("st_rel_inst", id_instr,  16'h0005);
        check("st_rel_req",  imem_req,  1'b1);
        check("st_rel_addr", imem_addr, 8'h06);
        tick();
        check("st_next_pc", id_pc, 8'h06);

        // redirect to 0x40 while addr 7 is outstanding
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        check("rd_c8_addr", imem_addr, 8'h06);
        auto_mem = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("rd_c9_addr", imem_addr, 8'h07);
        check("rd_c9_pc",   id_pc,     8'h06);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check("rd_bub_valid",  id_valid,  1'b0);
        check("rd_bub_opcode", id_opcode, 4'hF);
        check("rd_bub_instr",  id_instr,  16'hF000);
        check("rd_bub_pc",     id_pc,     8'h06);
        check("rd_drop_req",   imem_req,  1'b1);
        check("rd_drop_addr",  imem_addr, 8'h07);
        tick();
        check("rd_c11_addr", imem_addr, 8'h07);
        imem_ack   = 1'b1;
        imem_rdata = 16'h0007;
        tick();
        imem_ack = 1'b0;
        check("rd_tgt_req",   imem_req,  1'b1);
        check("rd_tgt_addr",  imem_addr, 8'h40);
        check("rd_discard",   id_valid,  1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h0040;
        tick();
        imem_ack = 1'b0;
        check("rd_tgt_valid", id_valid, 1'b1);
        check("rd_tgt_pc",    id_pc,    8'h40);
        check("rd_tgt_instr", id_instr, 16'h0040);

        // redirect coinciding with ack while stalled
        imem_ack       = 1'b1;
        imem_rdata     = 16'h0041;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        id_stall       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        check("rs_valid",  id_valid,  1'b0);
        check("rs_opcode", id_opcode, 4'hF);
        check("rs_pc",     id_pc,     8'h40);
        check("rs_req",    imem_req,  1'b1);
        check("rs_addr",   imem_addr, 8'h80);
        id_stall   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h0080;
        tick();
        check("rs_new_valid", id_valid, 1'b1);
        check("rs_new_pc",    id_pc,    8'h80);

        // pc wrap at 0xFF
        imem_rdata     = 16'h0081;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        check("wr_addr_ff", imem_addr, 8'hFF);
        imem_ack   = 1'b1;
        imem_rdata = 16'h00FF;
        tick();
        imem_ack = 1'b0;
        check("wr_pc_ff",   id_pc,     8'hFF);
        check("wr_instr",   id_instr,  16'h00FF);
        check("wr_addr_00", imem_addr, 8'h00);
        check("wr_req",     imem_req,  1'b1);
        tick();
        check("wr_wait_addr", imem_addr, 8'h00);
        check("wr_wait_pc",   id_pc,     8'hFF);

        // async reset mid-wait, then an ack during reset is ignored
        #2;
        rst = 1'b1;
        #1;
        check("ar_req",    imem_req,  1'b0);
        check("ar_addr",   imem_addr, 8'h00);
        check("ar_valid",  id_valid,  1'b0);
        check("ar_instr",  id_instr,  16'hF000);
        check("ar_opcode", id_opcode, 4'hF);
        check("ar_pc",     id_pc,     8'h00);
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        @(posedge clk);
        #1;
        check("ar_ack_req",   imem_req, 1'b0);
        check("ar_ack_valid", id_valid, 1'b0);
        check("ar_ack_pc",    id_pc,    8'h00);
        check("ar_ack_instr", id_instr, 16'hF000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage for the 4-bit-opcode pipeline. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It registers each fetched instruction into the IF/ID register, whose opcode field drives the control decoder directly downstream. It honours decode stalls and redirect flushes, and presents a NOP bubble (opcode 4'b1111) whenever no valid instruction is held.

## Interface
- PC_W, 8: program-counter / instruction-address width (word addressed)
- INSTR_W, 16: instruction width; opcode = instr[INSTR_W-1 -: 4]
- RESET_PC, 0: PC value loaded on reset
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  read request; held high until imem_ack
- imem_addr  out  PC_W  read word address; stable while imem_req=1
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  instruction word
- id_stall  in  1  decode cannot accept; IF/ID must hold
- redirect_valid  in  1  branch/jump redirect, one-cycle pulse
- redirect_pc  in  PC_W  redirect target
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  INSTR_W  IF/ID instruction (NOP 16'hF000 when id_valid=0)
- id_opcode  out  4  id_instr opcode field, to the control decoder
- id_pc  out  PC_W  address of id_instr

## Operation
- State machine has four states: IDLE, FETCH, HOLD, DROP.
  - imem_req = (state==FETCH || state==DROP).
  - imem_addr = pc.
- IDLE: entered on reset. Goes to FETCH after one cycle, or loads redirect_pc first if redirect_valid.
- FETCH:
  - On imem_ack with id_stall=0: IF/ID <= {1, rdata, pc}, pc <= pc+1, stay in FETCH.
  - On imem_ack with id_stall=1: rdata and pc go to the skid buffer, pc <= pc+1, go to HOLD.
- HOLD:
  - imem_req=0.
  - When id_stall falls: IF/ID <= skid, go to FETCH.
- DROP:
  - Entered when a redirect arrives while a request is outstanding and no ack arrives that cycle.
  - imem_req stays high at the old address, because the protocol forbids retracting a request.
  - On ack: discard the data, pc <= the saved redirect target, go to FETCH.
- Redirect, any state:
  - IF/ID <= bubble {0, 16'hF000, IF/ID pc}, and the skid buffer is invalidated.
  - In FETCH with ack in the same cycle: discard the data, pc <= redirect_pc, stay in FETCH.
  - In FETCH without ack: save the target, go to DROP.
  - In HOLD or IDLE: pc <= redirect_pc, go to FETCH.
  - In DROP: overwrite the saved target.
- Priority: redirect > stall > normal advance. The bubble load happens even when id_stall=1.
- With id_stall=1 and no redirect, IF/ID is unchanged in every state.
- PC increment is modulo 2^PC_W and wraps silently.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_instr=16'hF000, id_opcode=4'b1111, id_pc=RESET_PC.
  - Skid buffer invalid.
- First imem_req is asserted in the 2nd cycle after rst deasserts.
- Latency: imem_ack in cycle N -> id_valid/id_instr updated at the edge ending N, visible in N+1.
- Throughput: with a zero-wait memory (ack in the first req cycle), one instruction per cycle and imem_req continuously high.
- Redirect at cycle N -> bubble visible in N+1. The first request to the target is in N+1, or the cycle after the dropped ack.
- Reset asserted mid-fetch clears everything at once. An ack arriving during reset is ignored.

## Structure
- Shared cpu package holds:
  - OPC_W = 4
  - OPC_NOP = 4'b1111
  - NOP_INSTR = 16'hF000
  - an if_state enum {IDLE, FETCH, HOLD, DROP}
  - the opcode constants used by the control decoder (ADD 0, ADDI 1, SUB 2, AND 3, OR 4, LW 8, SW 9, NOP 15)
- Natural sub-module: if_id_reg, the IF/ID register with load/bubble/hold controls. Everything else stays in if_stage.

## Test plan
- Reset release, zero-wait memory returning mem[a]=16'h0000+a:
  - First req appears at cycle 2 with addr 0.
  - Then id_pc=0,1,2,… on consecutive cycles with id_valid=1 and id_opcode=0.
- 3-cycle memory latency:
  - imem_addr holds at 0 until ack.
  - id_valid rises the cycle after ack.
  - Next req appears at addr 1 in the same cycle as the update.
- id_stall held for 4 cycles while the fetch of addr 5 acks:
  - State goes to HOLD with req=0 and IF/ID frozen at pc 4.
  - After release, id_pc=5, then the fetch of 6 begins.
- redirect_valid to 0x40 while the fetch of addr 7 is outstanding (ack 2 cycles later):
  - Bubble presented (id_opcode=4'b1111).
  - Addr 7 is held until its ack, then its data is discarded.
  - Next req is to 0x40; id_pc=0x40 follows.
- Redirect in the same cycle as ack, with id_stall=1:
  - Ack data is dropped and a bubble is loaded despite the stall.
  - pc=target; no instruction with the old pc ever appears.
- pc=8'hFF fetched:
  - Next imem_addr=8'h00.
  - rst pulsed mid-wait: all outputs return to reset values asynchronously.
